// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: four-mode SPI master, one word per start; define SPI_CTRL_LSB_FIRST_EN for LSB-first shifting
module spi_master_ctrl #(
  parameter int DATA_W = 8,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              miso,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              cs,
  output logic              sclk,
  output logic              mosi
);
  localparam int CNT_W = $clog2(2 * DATA_W + 1);
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(2 * DATA_W);
  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;
  state_t state, state_nxt;
  logic [1:0] mode_r;
  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [DATA_W-1:0] tx_sr, rx_sr, tx_src, tx_shift, rx_shift;
  logic tick, lead, emit, smp, tx_bit;
  assign tick = state != IDLE && div == DIV_W'(CLK_DIV - 1);
  assign cnt_nxt = cnt + 1'b1;
  assign lead = cnt_nxt[0];
  assign emit = tick && state != HOLD && (mode_r[0] ? lead : !lead && cnt_nxt != LAST);
  assign smp = tick && state != HOLD && (mode_r[0] != lead);
  always_comb begin
    tx_src = state == IDLE ? tx_data : tx_sr;
`ifdef SPI_CTRL_LSB_FIRST_EN
    tx_bit = tx_src[0];
    tx_shift = tx_src >> 1;
    rx_shift = {miso, rx_sr[DATA_W-1:1]};
`else
    tx_bit = tx_src[DATA_W-1];
    tx_shift = tx_src << 1;
    rx_shift = {rx_sr[DATA_W-2:0], miso};
`endif
  end
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (start ? SETUP : IDLE) :
                !tick          ? state :
                state == HOLD  ? IDLE :
                cnt_nxt == LAST ? HOLD : XFER;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_nxt;
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_r <= '0;
      div <= '0;
      cnt <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
      rx_data <= busy ? rx_data : '0;
      busy <= 1'b0;
      done <= 1'b0;
      cs <= 1'b1;
      sclk <= 1'b0;
      mosi <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        mode_r <= mode;
        sclk <= mode[1];
        div <= '0;
        cnt <= '0;
        if (start) begin
          tx_sr <= mode[0] ? tx_data : tx_shift;
          mosi <= mode[0] ? 1'b0 : tx_bit;
          cs <= 1'b0;
          busy <= 1'b1;
        end
      end else begin
        div <= tick ? '0 : div + 1'b1;
        if (tick) begin
          cnt <= cnt_nxt;
          if (state != HOLD) sclk <= mode_r[1] ^ lead;
          if (emit) begin
            tx_sr <= tx_shift;
            mosi <= tx_bit;
          end
          if (smp) rx_sr <= rx_shift;
          if (state == HOLD) begin
            cs <= 1'b1;
            mosi <= 1'b0;
            busy <= 1'b0;
            done <= 1'b1;
            rx_data <= rx_sr;
          end
        end
      end
    end
  end
endmodule
